// File: rtl/key_input_conditioner_if.sv
// Key conditioner bus: raw active-low keys in, conditioned per-key flags out.
interface key_input_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] KEY;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] key_event;

    // Drives the buttons and consumes the conditioned flags.
    modport master (
        output KEY,
        input  key_level, key_press, key_release, key_repeat, key_event
    );

    // The conditioner itself.
    modport slave (
        input  KEY,
        output key_level, key_press, key_release, key_repeat, key_event
    );
endinterface

// File: rtl/key_input_conditioner.sv
// Push-button front end: 2-flop synchronizer, debounce, press/release pulses
// and optional auto-repeat, one independent channel per key.

module kic_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt,
    output logic evt
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;

    logic          s1, s2;
    logic          flag;
    logic [CW-1:0] cnt;
    logic          commit;
    logic          lvl_nxt;

    // Two-flop synchronizer; resets to the released (high) raw level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    assign flag    = ~s2;
    assign commit  = (flag != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign lvl_nxt = commit ? flag : level;

    // Debounce: count consecutive disagreeing cycles, any agreement clears.
    // Press/release pulses come out on the same edge the level flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= commit & flag;
            rel   <= commit & ~flag;
            if (flag == level) begin
                cnt <= '0;
            end else if (commit) begin
                cnt   <= '0;
                level <= flag;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    if (REPEAT_EN) begin : g_rep
        rstate_t       st, st_n;
        logic [TW-1:0] tmr, tmr_n;
        logic          rpt_n;

        // Repeat FSM state, timer and registered repeat/event pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st  <= IDLE;
                tmr <= '0;
                rpt <= 1'b0;
                evt <= 1'b0;
            end else begin
                st  <= st_n;
                tmr <= tmr_n;
                rpt <= rpt_n;
                evt <= rpt_n | (commit & flag);
            end
        end

        // Next state: arm on the accepted press (same edge as the press
        // pulse) so the first repeat lands REPEAT_DELAY cycles after it;
        // a falling level always wins over a due repeat.
        always_comb begin
            st_n  = st;
            tmr_n = tmr;
            rpt_n = 1'b0;
            case (st)
                IDLE: begin
                    if (commit && flag) begin
                        st_n  = DELAY;
                        tmr_n = '0;
                    end
                end
                DELAY: begin
                    if (!lvl_nxt) begin
                        st_n  = IDLE;
                        tmr_n = '0;
                    end else if (tmr == TW'(REPEAT_DELAY - 1)) begin
                        rpt_n = 1'b1;
                        st_n  = REPEAT;
                        tmr_n = '0;
                    end else begin
                        tmr_n = tmr + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!lvl_nxt) begin
                        st_n  = IDLE;
                        tmr_n = '0;
                    end else if (tmr == TW'(REPEAT_RATE - 1)) begin
                        rpt_n = 1'b1;
                        tmr_n = '0;
                    end else begin
                        tmr_n = tmr + TW'(1);
                    end
                end
                default: begin
                    st_n  = IDLE;
                    tmr_n = '0;
                end
            endcase
        end
    end else begin : g_norep
        assign rpt = 1'b0;

        // Without repeat the event output is just the press pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) evt <= 1'b0;
            else        evt <= commit & flag;
        end
    end
endmodule

module key_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    key_input_conditioner_if.slave   kif
);
    logic [NUM_KEYS-1:0] lvl, prs, rls, rpt, evt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        kic_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .key_raw (kif.KEY[i]),
            .level   (lvl[i]),
            .press   (prs[i]),
            .rel     (rls[i]),
            .rpt     (rpt[i]),
            .evt     (evt[i])
        );
    end

    assign kif.key_level   = lvl;
    assign kif.key_press   = prs;
    assign kif.key_release = rls;
    assign kif.key_repeat  = rpt;
    assign kif.key_event   = evt;
endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench: directed test-plan steps plus random key activity, checked every
// cycle against a window/arithmetic model of the debounce and repeat rules.
module tb_key_input_conditioner;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key = '1;
    int            checks = 0;
    int            failures = 0;

    key_input_conditioner_if #(.NUM_KEYS(NK)) kif0 ();
    key_input_conditioner_if #(.NUM_KEYS(NK)) kif1 ();
    assign kif0.KEY = key;
    assign kif1.KEY = key;

    key_input_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .kif(kif0));

    key_input_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_norep (
        .CLOCK_50(clk), .RESET_N(rst_n), .kif(kif1));

    always #5 clk = ~clk;

    // Model state: raw samples from the last two edges, the last DB pressed
    // flags, accepted level, and the edge index of each key's press.
    bit [NK-1:0] r1, r2, m_lvl, e_prs, e_rel, e_rep;
    bit          win[NK][DB];
    int          tp[NK];
    int          cyc = 0;

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        r1 = '1; r2 = '1; m_lvl = '0; e_prs = '0; e_rel = '0; e_rep = '0;
        for (int k = 0; k < NK; k++)
            for (int j = 0; j < DB; j++) win[k][j] = 1'b0;
    endtask

    task automatic check_all();
        chk("level",        kif0.key_level,   m_lvl);
        chk("press",        kif0.key_press,   e_prs);
        chk("release",      kif0.key_release, e_rel);
        chk("repeat",       kif0.key_repeat,  e_rep);
        chk("event",        kif0.key_event,   e_prs | e_rep);
        chk("norep_level",  kif1.key_level,   m_lvl);
        chk("norep_press",  kif1.key_press,   e_prs);
        chk("norep_release",kif1.key_release, e_rel);
        chk("norep_repeat", kif1.key_repeat,  '0);
        chk("norep_event",  kif1.key_event,   e_prs);
    endtask

    task automatic tick();
        bit flag, flip;
        int d;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < NK; k++) begin
                flag  = ~r2[k];
                r2[k] = r1[k];
                r1[k] = key[k];
                for (int j = DB - 1; j > 0; j--) win[k][j] = win[k][j-1];
                win[k][0] = flag;
                flip = 1'b1;
                for (int j = 0; j < DB; j++) if (win[k][j] == m_lvl[k]) flip = 1'b0;
                e_prs[k] = 1'b0; e_rel[k] = 1'b0; e_rep[k] = 1'b0;
                if (flip) begin
                    m_lvl[k] = ~m_lvl[k];
                    e_prs[k] = m_lvl[k];
                    e_rel[k] = ~m_lvl[k];
                    if (m_lvl[k]) tp[k] = cyc;
                end
                if (m_lvl[k] && !e_prs[k]) begin
                    d = cyc - tp[k];
                    e_rep[k] = (d >= RD) && ((d - RD) % RR == 0);
                end
            end
        end
        cyc++;
        #1;
        check_all();
    endtask

    int dur[NK];

    initial begin
        model_reset();
        for (int k = 0; k < NK; k++) begin tp[k] = 0; dur[k] = 0; end

        // Reset held with keys released, then idle keys for 100 cycles.
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();

        // Single clean press / release on KEY[0].
        key[0] = 1'b0; repeat (30) tick();
        key[0] = 1'b1; repeat (10) tick();

        // Bounce on KEY[1] never long enough to be accepted.
        key[1] = 1'b0; repeat (3) tick();
        key[1] = 1'b1; repeat (1) tick();
        key[1] = 1'b0; repeat (3) tick();
        key[1] = 1'b1; repeat (15) tick();

        // Long hold on KEY[2] for repeat timing, then release.
        key[2] = 1'b0; repeat (40) tick();
        key[2] = 1'b1; repeat (15) tick();

        // Simultaneous press on KEY[0] and KEY[3].
        key[0] = 1'b0; key[3] = 1'b0; repeat (30) tick();
        key[0] = 1'b1; key[3] = 1'b1; repeat (10) tick();

        // Async reset while KEY[2] is in the repeat phase, key kept held.
        key[2] = 1'b0; repeat (25) tick();
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        key[2] = 1'b1; repeat (10) tick();

        // Random activity: short bounces and longer holds on every key.
        repeat (800) begin
            for (int k = 0; k < NK; k++) begin
                if (dur[k] == 0) begin
                    key[k] = 1'($urandom_range(0, 1));
                    dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40)
                                                         : $urandom_range(1, 6);
                end
                dur[k]--;
            end
            tick();
        end
        key = '1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
